unified_mem_arbiter: RTL

- Arbitrates one single-ported unified RAM between the instruction-fetch path (IF stage) and the data path (MEM stage) of the 5-stage MIPS pipeline.
- Serialises accesses with a small FSM and fixed MEM-over-IF priority.
- Returns data with a one-cycle ready pulse and raises combinational stall signals that freeze the pipeline while an access is outstanding.

---
 rtl/unified_mem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbitrates a single-port unified RAM between IF fetches and MEM loads/stores, MEM first.
// Optional ram_ack timeout with sticky err is enabled by defining ARB_TIMEOUT_EN.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              mem_r_en_i,
  input  logic              mem_w_en_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ready_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic              ram_ack_i,
  output logic              if_stall_o,
  output logic              mem_stall_o,
  output logic              err_o
);

  typedef enum logic [1:0] {StIdle, StBusyMem, StBusyIf, StResp} state_e;

  state_e            state_q, state_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              mem_ready_q, mem_ready_d;

  logic              mem_req;
  logic              busy;
  logic              timeout_hit;
  logic [DATA_W-1:0] rd_val;

  assign mem_req = mem_r_en_i | mem_w_en_i;
  assign busy    = (state_q == StBusyMem) || (state_q == StBusyIf);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // A same-cycle ack always beats the timeout.
  assign timeout_hit = busy & ~ram_ack_i & (cnt_q == CntW'(TIMEOUT - 1));
  assign rd_val      = ram_ack_i ? ram_rdata_i : DATA_W'(32'hDEADBEEF);

  always_comb begin
    cnt_d = busy ? cnt_q + CntW'(1) : '0;
    err_d = err_q | timeout_hit;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
  assign rd_val         = ram_rdata_i;
  assign err_o          = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ram_req_d   = ram_req_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (mem_req) begin
          ram_req_d   = 1'b1;
          ram_we_d    = mem_w_en_i;
          ram_addr_d  = mem_addr_i;
          ram_wdata_d = mem_wdata_i;
          state_d     = StBusyMem;
        end else if (if_req_i) begin
          ram_req_d  = 1'b1;
          ram_we_d   = 1'b0;
          ram_addr_d = if_addr_i;
          state_d    = StBusyIf;
        end
      end
      StBusyMem, StBusyIf: begin
        if (ram_ack_i || timeout_hit) begin
          ram_req_d = 1'b0;
          state_d   = StResp;
          if (state_q == StBusyMem) begin
            mem_ready_d = 1'b1;
            if (!ram_we_q) begin
              mem_rdata_d = rd_val;
            end
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = rd_val;
          end
        end
      end
      // Ready pulses here; no grant so a still-held request is not re-issued.
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  assign ram_req_o   = ram_req_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign mem_ready_o = mem_ready_q;
  assign if_stall_o  = if_req_i & ~if_ready_q;
  assign mem_stall_o = mem_req & ~mem_ready_q;

endmodule
